// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, widths and address check for the data-memory responder
//
// Purpose:
//   Shared definitions for dmem_responder and dmem_array.
//   Provides the responder state encoding, the data and strobe widths, and the
//   misaligned/out-of-range address check.

package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // The access faults if the byte address is not word aligned or if the word
    // index falls beyond the array. The range test uses the full upper address,
    // so aliasing of high address bits onto the array index cannot happen.
    function automatic logic is_err(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port word RAM with byte write enables and registered read data
//
// Purpose:
//   DEPTH_WORDS x WORD_W storage. One access per enabled cycle: either a byte-masked
//   write or a read whose data lands in an output register. That register only
//   changes on an enabled read, so it holds its value while the response is pending.
// Ports:
//   clk_i    in   clock
//   en_i     in   perform an access this edge
//   we_i     in   1 = write, 0 = read
//   addr_i   in   word index
//   wdata_i  in   write data
//   wstrb_i  in   byte enables for the write
//   rdata_o  out  registered read data

module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [STRB_W-1:0] wstrb_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (wstrb_i[b]) begin
                        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage data-memory responder with fixed access latency
//
// Purpose:
//   Accepts one load or store at a time, services it against dmem_array after
//   LATENCY cycles and returns read data plus an error flag. stall_o freezes the
//   pipeline while an access is outstanding.
// Ports:
//   clk_i        in   clock, rising edge
//   rst_i        in   synchronous active-high reset
//   req_valid_i  in   request present
//   req_ready_o  out  request can be accepted (IDLE)
//   req_write_i  in   1 = store, 0 = load
//   req_addr_i   in   byte address
//   req_wdata_i  in   store data
//   req_wstrb_i  in   store byte enables
//   rsp_valid_o  out  response present (RESP)
//   rsp_ready_i  in   requester takes the response
//   rsp_rdata_o  out  load data, 0 for stores and errors
//   rsp_err_o    out  misaligned or out-of-range access
//   stall_o      out  pipeline freeze request

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [31:0]       req_addr_i,
    input  logic [WORD_W-1:0] req_wdata_i,
    input  logic [STRB_W-1:0] req_wstrb_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [WORD_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              stall_o
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              write_q;
    logic [31:0]       addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              err_q;
    logic              load_q;

    logic              accept;
    logic              enter_resp;
    logic              cur_write;
    logic [31:0]       cur_addr;
    logic [WORD_W-1:0] cur_wdata;
    logic [STRB_W-1:0] cur_wstrb;
    logic              cur_err;
    logic              ram_en;
    logic [WORD_W-1:0] ram_rdata;

    assign accept = (state_q == IDLE) && req_valid_i;

    // With LATENCY==1 the RAM is accessed on the accept edge itself, before the
    // request latch holds anything, so the live request fields are used in IDLE.
    // In WAIT the latched copy is used and later req_* changes are ignored.
    assign cur_write = (state_q == IDLE) ? req_write_i : write_q;
    assign cur_addr  = (state_q == IDLE) ? req_addr_i  : addr_q;
    assign cur_wdata = (state_q == IDLE) ? req_wdata_i : wdata_q;
    assign cur_wstrb = (state_q == IDLE) ? req_wstrb_i : wstrb_q;
    assign cur_err   = is_err(cur_addr, DEPTH_WORDS);

    // Reset on the commit edge drops the store; faulting accesses never touch the RAM.
    assign ram_en = enter_resp && !cur_err && !rst_i;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                        cnt_d      = 4'd0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                    cnt_d      = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= '0;
            wstrb_q <= '0;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                write_q <= req_write_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                wstrb_q <= req_wstrb_i;
            end
            if (enter_resp) begin
                err_q  <= cur_err;
                load_q <= !cur_write && !cur_err;
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk_i   (clk_i),
        .en_i    (ram_en),
        .we_i    (cur_write),
        .addr_i  (cur_addr[AW+1:2]),
        .wdata_i (cur_wdata),
        .wstrb_i (cur_wstrb),
        .rdata_o (ram_rdata)
    );

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_err_o   = (state_q == RESP) && err_q;
    assign rsp_rdata_o = ((state_q == RESP) && load_q) ? ram_rdata : '0;

    assign stall_o = (state_q == WAIT)
                   || ((state_q == RESP) && !rsp_ready_i)
                   || ((state_q == IDLE) && req_valid_i);

endmodule
